// File: rtl/ethernet_rr_mux_n_avlstrm.sv
// Ethernet ingress pass-through, round-robin egress merge and packet counters.
// Optional macro ETH_MUX_CHAN_STATS_EN adds one packet counter per egress source.
//
// stats_packer_avlstrm: cycles through NREC 48-bit records {addr[47:32], value[31:0]}.
//   Clk, Rst_n       clock, synchronous active-low reset
//   i_vals           record values, index = register address
//   o_data/o_sop/o_eop/o_valid, i_ready   record stream (sop on addr 0, eop on last)
//
// ethernet_rr_mux_n_avlstrm:
//   Clk, Rst_n                     clock, synchronous active-low reset
//   i_eth_in_* / o_eth_in_ready    packet stream from the MAC
//   o_in_* / i_in_ready            ingress stream to the pipeline (combinational copy)
//   i_out_* / o_out_ready          NUM_OUT egress sources, index 0 first
//   o_eth_out_* / i_eth_out_ready  registered merged egress stream to the MAC
//   o_stats_* / i_stats_ready      counter records: REG_IN_PKT, REG_OUT_PKT, REG_CHAN_PKT_BASE+i

module stats_packer_avlstrm #(
    parameter int NREC = 2
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [NREC-1:0][31:0] i_vals,
    output logic [47:0]           o_data,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic                  o_valid,
    input  logic                  i_ready
);

    localparam int IDX_W = (NREC > 1) ? $clog2(NREC) : 1;

    logic [IDX_W-1:0] r_idx;
    logic [47:0]      r_data;
    logic             r_sop;
    logic             r_eop;
    logic             r_valid;
    logic             w_load;

    assign w_load = !r_valid || i_ready;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_idx   <= '0;
            r_data  <= '0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= {16'(r_idx), i_vals[r_idx]};
            r_sop   <= (r_idx == '0);
            r_eop   <= (r_idx == IDX_W'(NREC - 1));
            r_idx   <= (r_idx == IDX_W'(NREC - 1)) ? '0 : r_idx + 1'b1;
        end
    end

    assign o_data  = r_data;
    assign o_sop   = r_sop;
    assign o_eop   = r_eop;
    assign o_valid = r_valid;

endmodule

module ethernet_rr_mux_n_avlstrm #(
    parameter int NUM_OUT = 5,
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6
) (
    input  logic                              Clk,
    input  logic                              Rst_n,
    input  logic [DATA_W-1:0]                 i_eth_in_data,
    input  logic                              i_eth_in_sop,
    input  logic                              i_eth_in_eop,
    input  logic [EMPTY_W-1:0]                i_eth_in_empty,
    input  logic                              i_eth_in_valid,
    output logic                              o_eth_in_ready,
    output logic [DATA_W-1:0]                 o_in_data,
    output logic                              o_in_sop,
    output logic                              o_in_eop,
    output logic [EMPTY_W-1:0]                o_in_empty,
    output logic                              o_in_valid,
    input  logic                              i_in_ready,
    input  logic [NUM_OUT-1:0][DATA_W-1:0]    i_out_data,
    input  logic [NUM_OUT-1:0]                i_out_sop,
    input  logic [NUM_OUT-1:0]                i_out_eop,
    input  logic [NUM_OUT-1:0][EMPTY_W-1:0]   i_out_empty,
    input  logic [NUM_OUT-1:0]                i_out_valid,
    output logic [NUM_OUT-1:0]                o_out_ready,
    output logic [DATA_W-1:0]                 o_eth_out_data,
    output logic                              o_eth_out_sop,
    output logic                              o_eth_out_eop,
    output logic [EMPTY_W-1:0]                o_eth_out_empty,
    output logic                              o_eth_out_valid,
    input  logic                              i_eth_out_ready,
    output logic [47:0]                       o_stats_data,
    output logic                              o_stats_sop,
    output logic                              o_stats_eop,
    output logic                              o_stats_valid,
    input  logic                              i_stats_ready
);

    localparam int IDX_W             = $clog2(NUM_OUT);
    localparam int REG_IN_PKT        = 0;
    localparam int REG_OUT_PKT       = 1;
    localparam int REG_CHAN_PKT_BASE = 2;
`ifdef ETH_MUX_CHAN_STATS_EN
    localparam int NREC = REG_CHAN_PKT_BASE + NUM_OUT;
`else
    localparam int NREC = REG_CHAN_PKT_BASE;
`endif

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_sel;
    logic [IDX_W-1:0] w_sel_inc;
    logic [IDX_W:0]   w_sum;
    logic             w_any;
    logic             w_has_grant;
    logic             w_can_load;
    logic             w_accept;
    logic             w_accept_eop;
    logic [NUM_OUT-1:0] w_ready;

    logic [DATA_W-1:0]  r_eo_data;
    logic               r_eo_sop;
    logic               r_eo_eop;
    logic [EMPTY_W-1:0] r_eo_empty;
    logic               r_eo_valid;

    logic [31:0] r_in_pkt;
    logic [31:0] r_out_pkt;
    logic [NREC-1:0][31:0] w_stats_vals;

    // Ingress is a straight wire copy.
    assign o_in_data      = i_eth_in_data;
    assign o_in_sop       = i_eth_in_sop;
    assign o_in_eop       = i_eth_in_eop;
    assign o_in_empty     = i_eth_in_empty;
    assign o_in_valid     = i_eth_in_valid;
    assign o_eth_in_ready = i_in_ready;

    // Scan from rr_ptr upward with wrap; descending loop so the
    // nearest valid index is the last one written.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        w_sum  = '0;
        for (int k = NUM_OUT - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_OUT)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_OUT);
            end
            if (i_out_valid[w_sum[IDX_W-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_sum[IDX_W-1:0];
            end
        end
    end

    // Output register can take a beat when empty or draining.
    assign w_can_load = !r_eo_valid || i_eth_out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_sel       = r_grant;
        w_has_grant = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_sel       = w_pick;
                w_has_grant = w_any;
            end
            ST_LOCKED: begin
                w_has_grant = 1'b1;
            end
            default: begin
                w_has_grant = 1'b0;
            end
        endcase
        w_accept     = w_has_grant && i_out_valid[w_sel]
                       && w_can_load && Rst_n;
        w_accept_eop = w_accept && i_out_eop[w_sel];
        if (w_accept) begin
            if (r_state == ST_IDLE && !i_out_eop[w_sel]) begin
                w_state_nxt = ST_LOCKED;
            end
            if (r_state == ST_LOCKED && i_out_eop[w_sel]) begin
                w_state_nxt = ST_IDLE;
            end
        end
        w_ready = '0;
        if (w_has_grant && w_can_load && Rst_n) begin
            w_ready[w_sel] = 1'b1;
        end
    end

    assign o_out_ready = w_ready;
    assign w_sel_inc   = (w_sel == IDX_W'(NUM_OUT - 1)) ? '0 : w_sel + 1'b1;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_accept && r_state == ST_IDLE) begin
                r_grant <= w_sel;
            end
            if (w_accept_eop) begin
                r_rr_ptr <= w_sel_inc;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_eo_data  <= '0;
            r_eo_sop   <= 1'b0;
            r_eo_eop   <= 1'b0;
            r_eo_empty <= '0;
            r_eo_valid <= 1'b0;
        end else if (w_accept) begin
            r_eo_data  <= i_out_data[w_sel];
            r_eo_sop   <= i_out_sop[w_sel];
            r_eo_eop   <= i_out_eop[w_sel];
            r_eo_empty <= i_out_empty[w_sel];
            r_eo_valid <= 1'b1;
        end else if (i_eth_out_ready) begin
            r_eo_valid <= 1'b0;
        end
    end

    assign o_eth_out_data  = r_eo_data;
    assign o_eth_out_sop   = r_eo_sop;
    assign o_eth_out_eop   = r_eo_eop;
    assign o_eth_out_empty = r_eo_empty;
    assign o_eth_out_valid = r_eo_valid;

    // in_pkt ignores ready to match the legacy ingress count.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_in_pkt  <= '0;
            r_out_pkt <= '0;
        end else begin
            if (i_eth_in_valid && i_eth_in_eop) begin
                r_in_pkt <= r_in_pkt + 32'd1;
            end
            if (r_eo_valid && i_eth_out_ready && r_eo_eop) begin
                r_out_pkt <= r_out_pkt + 32'd1;
            end
        end
    end

`ifdef ETH_MUX_CHAN_STATS_EN
    logic [NUM_OUT-1:0][31:0] r_chan_pkt;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_chan_pkt <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (w_accept_eop && (w_sel == IDX_W'(i))) begin
                    r_chan_pkt[i] <= r_chan_pkt[i] + 32'd1;
                end
            end
        end
    end

    assign w_stats_vals = {r_chan_pkt, r_out_pkt, r_in_pkt};
`else
    assign w_stats_vals = {r_out_pkt, r_in_pkt};
`endif

    stats_packer_avlstrm #(
        .NREC (NREC)
    ) u_stats (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .i_vals  (w_stats_vals),
        .o_data  (o_stats_data),
        .o_sop   (o_stats_sop),
        .o_eop   (o_stats_eop),
        .o_valid (o_stats_valid),
        .i_ready (i_stats_ready)
    );

endmodule
